// File: rtl/fetcher_if.sv
// Fetcher-side bus bundle: instruction-cache request/response and the
// presented-instruction handshake towards the decoder.
interface fetcher_if;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_data;
  logic        inst_valid;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic [31:0] f_next_pc;
  logic        f_ok;

  modport master (
    output ic_req_valid, ic_req_addr,
    input  ic_resp_valid, ic_resp_data,
    output inst_valid, inst_addr, inst_data,
    input  f_next_pc, f_ok
  );

  modport slave (
    input  ic_req_valid, ic_req_addr,
    output ic_resp_valid, ic_resp_data,
    input  inst_valid, inst_addr, inst_data,
    output f_next_pc, f_ok
  );
endinterface

// File: rtl/fetcher.sv
// Single-outstanding instruction fetcher: requests one word at pc, presents it
// to the decoder until accepted, and drops responses made stale by a flush.
module fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic [31:0] rob_clear_pc,
  fetcher_if.master   bus
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic        resp_take;

  // A response is only consumed while the pipeline runs; during a pause the
  // cache keeps presenting it, even if a flush arrives meanwhile.
  assign resp_take = bus.ic_resp_valid & rdy_in;

  always_comb begin
    // NOTE: every next value defaults to the current one first, so no path infers a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    req_valid_d  = req_valid_q;
    req_addr_d   = req_addr_q;
    inst_valid_d = inst_valid_q;
    inst_addr_d  = inst_addr_q;
    inst_data_d  = inst_data_q;

    if (rob_clear) begin
      pc_d         = rob_clear_pc;
      inst_valid_d = 1'b0;
      unique case (state_q)
        FETCH, HOLD: state_d = FETCH;
        WAIT, FLUSH: begin
          if (resp_take) begin
            req_valid_d = 1'b0;
            state_d     = FETCH;
          end else begin
            state_d     = FLUSH;
          end
        end
      endcase
    end else if (rdy_in) begin
      unique case (state_q)
        FETCH: begin
          req_valid_d = 1'b1;
          req_addr_d  = pc_q;
          state_d     = WAIT;
        end
        WAIT: begin
          if (resp_take) begin
            req_valid_d  = 1'b0;
            inst_valid_d = 1'b1;
            inst_addr_d  = pc_q;
            inst_data_d  = bus.ic_resp_data;
            state_d      = HOLD;
          end
        end
        HOLD: begin
          if (bus.f_ok) begin
            inst_valid_d = 1'b0;
            pc_d         = bus.f_next_pc;
            state_d      = FETCH;
          end
        end
        FLUSH: begin
          // The in-flight word belongs to the abandoned path; retire it unseen.
          if (resp_take) begin
            req_valid_d = 1'b0;
            state_d     = FETCH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      inst_valid_q <= 1'b0;
      inst_addr_q  <= '0;
      inst_data_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values of the others.
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      inst_valid_q <= inst_valid_d;
      inst_addr_q  <= inst_addr_d;
      inst_data_q  <= inst_data_d;
    end
  end

  assign bus.ic_req_valid = req_valid_q;
  assign bus.ic_req_addr  = req_addr_q;
  assign bus.inst_valid   = inst_valid_q;
  assign bus.inst_addr    = inst_addr_q;
  assign bus.inst_data    = inst_data_q;

endmodule

// File: tb/tb_fetcher.sv
// Bench for fetcher: directed scenarios then randomized traffic, all outputs
// compared every cycle against a request/present-level reference model.
module tb_fetcher;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_in       = 1'b0;
  logic        rst_in       = 1'b0;
  logic        rdy_in       = 1'b0;
  logic        rob_clear    = 1'b0;
  logic [31:0] rob_clear_pc = '0;

  int n_cmp = 0;
  int n_bad = 0;

  fetcher_if bus ();

  fetcher #(.RESET_PC(RESET_PC)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .rob_clear   (rob_clear),
    .rob_clear_pc(rob_clear_pc),
    .bus         (bus)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: outstanding request, presented instruction, fetch pc.
  logic        m_rv, m_iv, m_stale;
  logic [31:0] m_pc, m_ra, m_ia, m_id;

  // Cache model: one outstanding read, answered after c_lat extra cycles.
  logic        c_busy;
  logic [31:0] c_addr;
  int          c_lat;
  int          force_lat = -1;

  logic [31:0] seq_pcs [3] = '{32'd4, 32'd8, 32'd12};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0093;
    if (a == 32'h8) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_rv    = 1'b0;
    m_iv    = 1'b0;
    m_stale = 1'b0;
    m_ra    = '0;
    m_ia    = '0;
    m_id    = '0;
    c_busy  = 1'b0;
    c_lat   = 0;
    c_addr  = '0;
    bus.ic_resp_valid = 1'b0;
    bus.ic_resp_data  = '0;
  endtask

  task automatic compare_all();
    check("ic_req_valid", 32'(bus.ic_req_valid), 32'(m_rv));
    check("ic_req_addr",  bus.ic_req_addr,       m_ra);
    check("inst_valid",   32'(bus.inst_valid),   32'(m_iv));
    check("inst_addr",    bus.inst_addr,         m_ia);
    check("inst_data",    bus.inst_data,         m_id);
    if (m_iv) check("inst_vs_mem", bus.inst_data, mem_word(m_ia));
  endtask

  // One clock: advance the model on the inputs about to be sampled, clock,
  // compare at the falling edge, then let the cache react for the next edge.
  task automatic tick();
    logic took;
    took = bus.ic_resp_valid && rdy_in;
    if (rob_clear) begin
      m_iv = 1'b0;
      m_pc = rob_clear_pc;
      if (m_rv) begin
        if (took) begin
          m_rv    = 1'b0;
          m_stale = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end
    end else if (rdy_in) begin
      if (m_rv) begin
        if (took) begin
          m_rv = 1'b0;
          if (!m_stale) begin
            m_iv = 1'b1;
            m_ia = m_pc;
            m_id = bus.ic_resp_data;
          end
          m_stale = 1'b0;
        end
      end else if (m_iv) begin
        if (bus.f_ok) begin
          m_iv = 1'b0;
          m_pc = bus.f_next_pc;
        end
      end else begin
        m_rv = 1'b1;
        m_ra = m_pc;
      end
    end

    @(posedge clk_in);
    @(negedge clk_in);
    compare_all();

    if (took) begin
      bus.ic_resp_valid = 1'b0;
      c_busy = 1'b0;
    end
    if (!c_busy && bus.ic_req_valid) begin
      c_busy    = 1'b1;
      c_addr    = bus.ic_req_addr;
      c_lat     = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
      force_lat = -1;
    end
    if (c_busy && !bus.ic_resp_valid) begin
      if (c_lat == 0) begin
        bus.ic_resp_valid = 1'b1;
        bus.ic_resp_data  = mem_word(c_addr);
      end else begin
        c_lat--;
      end
    end
  endtask

  // Reset pulse strictly between clock edges; outputs must clear at once.
  task automatic async_reset_pulse();
    #1 rst_in = 1'b0;
    #1;
    check("arst_req_valid",  32'(bus.ic_req_valid), 32'h0);
    check("arst_req_addr",   bus.ic_req_addr,       32'h0);
    check("arst_inst_valid", 32'(bus.inst_valid),   32'h0);
    check("arst_inst_addr",  bus.inst_addr,         32'h0);
    check("arst_inst_data",  bus.inst_data,         32'h0);
    model_reset();
    #1 rst_in = 1'b1;
  endtask

  initial begin
    bus.f_ok      = 1'b0;
    bus.f_next_pc = '0;
    model_reset();
    repeat (2) @(negedge clk_in);
    compare_all();
    rst_in = 1'b1;
    rdy_in = 1'b1;

    // Cold start with single-cycle cache latency.
    force_lat = 0;
    tick();
    check("cold_req_addr", bus.ic_req_addr, RESET_PC);
    tick();
    check("cold_inst_valid", 32'(bus.inst_valid), 32'h1);
    check("cold_inst_addr",  bus.inst_addr,       32'h0);
    check("cold_inst_data",  bus.inst_data,       32'h0000_0093);

    // Sequential run.
    for (int i = 0; i < 3; i++) begin
      bus.f_ok      = 1'b1;
      bus.f_next_pc = seq_pcs[i];
      force_lat     = 0;
      tick();
      bus.f_ok = 1'b0;
      tick();
      check("seq_req_addr", bus.ic_req_addr, seq_pcs[i]);
      tick();
      check("seq_inst_addr", bus.inst_addr, seq_pcs[i]);
    end

    // Decoder back-pressure in HOLD.
    repeat (10) tick();
    check("bp_no_req",    32'(bus.ic_req_valid), 32'h0);
    check("bp_inst_addr", bus.inst_addr,         32'd12);
    bus.f_ok      = 1'b1;
    bus.f_next_pc = 32'h100;
    force_lat     = 0;
    tick();
    bus.f_ok = 1'b0;
    tick();
    check("bp_req_addr", bus.ic_req_addr, 32'h100);
    tick();

    // Flush while the request to 0x8 is pending; its response is dropped.
    bus.f_ok      = 1'b1;
    bus.f_next_pc = 32'h8;
    force_lat     = 2;
    tick();
    bus.f_ok = 1'b0;
    tick();
    check("flush_req_addr", bus.ic_req_addr, 32'h8);
    rob_clear    = 1'b1;
    rob_clear_pc = 32'h200;
    tick();
    rob_clear = 1'b0;
    tick();
    tick();
    check("flush_drop_iv",  32'(bus.inst_valid),   32'h0);
    check("flush_drop_req", 32'(bus.ic_req_valid), 32'h0);
    force_lat = 0;
    tick();
    check("flush_new_req", bus.ic_req_addr, 32'h200);

    // Clear coincident with a response in WAIT.
    rob_clear    = 1'b1;
    rob_clear_pc = 32'h300;
    tick();
    rob_clear = 1'b0;
    check("coin_resp_iv", 32'(bus.inst_valid), 32'h0);
    force_lat = 0;
    tick();
    check("coin_resp_req", bus.ic_req_addr, 32'h300);
    tick();
    check("coin_resp_inst", bus.inst_addr, 32'h300);

    // Clear coincident with decoder acceptance in HOLD.
    bus.f_ok      = 1'b1;
    bus.f_next_pc = 32'h400;
    rob_clear     = 1'b1;
    rob_clear_pc  = 32'h500;
    tick();
    bus.f_ok  = 1'b0;
    rob_clear = 1'b0;
    check("coin_ok_iv", 32'(bus.inst_valid), 32'h0);
    force_lat = 2;
    tick();
    check("coin_ok_req", bus.ic_req_addr, 32'h500);

    // Pause mid-WAIT, then asynchronous reset between edges.
    rdy_in = 1'b0;
    repeat (5) tick();
    check("stall_req_valid", 32'(bus.ic_req_valid), 32'h1);
    check("stall_inst_valid", 32'(bus.inst_valid), 32'h0);
    async_reset_pulse();
    rdy_in = 1'b1;
    tick();
    check("rst_first_req", bus.ic_req_addr, RESET_PC);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      rdy_in        = ($urandom_range(0, 7) != 0);
      rob_clear     = ($urandom_range(0, 19) == 0);
      rob_clear_pc  = $urandom();
      bus.f_ok      = ($urandom_range(0, 2) == 0);
      bus.f_next_pc = $urandom();
      if ($urandom_range(0, 599) == 0) async_reset_pulse();
      tick();
    end

    rob_clear = 1'b0;
    bus.f_ok  = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 SHALL define parameter RESET_PC, default 32'h00000000, as the first fetch address after reset.
REQ-002 SHALL have port clk_in, input, 1, the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_in, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port rdy_in, input, 1; when low, pipeline pause.
REQ-005 SHALL have port rob_clear, input, 1; mispredict flush request.
REQ-006 SHALL have port rob_clear_pc, input, 32; redirect target, valid with rob_clear.
REQ-007 SHALL have port ic_req_valid, output, 1; registered instruction-cache read request, held high until the response arrives.
REQ-008 SHALL have port ic_req_addr, output, 32; registered request address.
REQ-009 SHALL have port ic_resp_valid, input, 1; one-cycle pulse carrying the response.
REQ-010 SHALL have port ic_resp_data, input, 32; instruction word, valid with ic_resp_valid.
REQ-011 SHALL have port inst_valid, output, 1; registered, to decoder.
REQ-012 SHALL have port inst_addr, output, 32; registered PC of the presented instruction.
REQ-013 SHALL have port inst_data, output, 32; registered instruction word.
REQ-014 SHALL have port f_next_pc, input, 32; decoder-computed successor PC.
REQ-015 SHALL have port f_ok, input, 1; decoder accepted the presented instruction this cycle.

Function
REQ-016 SHALL implement states FETCH, WAIT, HOLD and FLUSH, plus a 32-bit pc register.
REQ-017 FETCH: SHALL register ic_req_valid=1 and ic_req_addr=pc, then go to WAIT; one request in flight maximum.
REQ-018 WAIT with ic_resp_valid: SHALL set ic_req_valid=0, inst_data=ic_resp_data, inst_addr=pc, inst_valid=1, and go to HOLD; inst_valid rises the cycle after the response.
REQ-019 WAIT without ic_resp_valid: SHALL hold all outputs unchanged.
REQ-020 HOLD: inst_valid, inst_addr and inst_data SHALL stay stable until f_ok is sampled high.
REQ-021 HOLD with f_ok: SHALL set inst_valid=0 and pc=f_next_pc (full 32 bits, no alignment masking), then go to FETCH.
REQ-022 Minimum issue interval is FETCH, WAIT, HOLD, with at least 3 cycles per instruction when the cache responds in the first WAIT cycle.
REQ-023 rob_clear SHALL take priority over all other events and act regardless of rdy_in.
REQ-024 rob_clear effect: SHALL set pc=rob_clear_pc and inst_valid=0; f_ok in the same cycle SHALL be ignored.
REQ-025 rob_clear in FETCH or HOLD: SHALL go to FETCH.
REQ-026 rob_clear in WAIT without response: SHALL keep ic_req_valid high and go to FLUSH.
REQ-027 rob_clear in WAIT with ic_resp_valid in the same cycle: SHALL discard the data, set ic_req_valid=0, and go to FETCH.
REQ-028 FLUSH: SHALL wait for ic_resp_valid, discard the data, set ic_req_valid=0, and go to FETCH.
REQ-029 rob_clear in FLUSH: SHALL update pc to rob_clear_pc and remain in FLUSH.
REQ-030 rdy_in low with no rob_clear: SHALL freeze state, pc and all outputs; ic_resp_valid arriving then is not captured, so the cache holds its response until rdy_in returns.
REQ-031 A stale response SHALL never reach inst_data or raise inst_valid.

Reset
REQ-032 rst_in low SHALL immediately force state=FETCH, pc=RESET_PC, ic_req_valid=0, ic_req_addr=0, inst_valid=0, inst_addr=0, inst_data=0.
REQ-033 Reset asserted mid-request SHALL abandon it; the cache is reset by the same signal.
REQ-034 After rst_in deasserts, the first rising edge with rdy_in high SHALL issue a request at RESET_PC.

Verification
REQ-035 Cold start: release reset, cache returns 32'h00000093 one cycle after the request -> ic_req_addr=0, then inst_valid=1 with inst_addr=0 and inst_data=32'h00000093.
REQ-036 Sequential run: f_ok=1 with f_next_pc=4, 8, 12 -> requests go to 4, 8, 12; every instruction is presented exactly once and is stable until f_ok.
REQ-037 Back-pressure: hold f_ok=0 for 10 cycles in HOLD -> outputs unchanged and no new request; f_ok=1 with f_next_pc=32'h100 -> next request at 32'h100.
REQ-038 Flush in WAIT: rob_clear with rob_clear_pc=32'h200 while the request to 32'h8 is pending; response 32'hDEADBEEF two cycles later -> it is dropped with inst_valid=0, and the next request goes to 32'h200.
REQ-039 Coincident events: rob_clear same cycle as ic_resp_valid in WAIT, and rob_clear same cycle as f_ok in HOLD -> the clear target wins in both cases and no instruction is presented.
REQ-040 Stall and async reset: rdy_in=0 for 5 cycles mid-WAIT leaves state frozen; pulsing rst_in low between clock edges clears all outputs immediately without waiting for a clock edge.
